// File: rtl/gshare_btb_controller.sv
// Gshare direction predictor + direct-mapped BTB; combinational lookup, one-cycle update visibility.
// No backpressure: updates are accepted every RUN cycle; ready is low while tables initialise.
module gshare_btb_controller #(
  parameter int INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           current_pc,
  output logic [31:0]           pc_predict,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] lookup_bhr,
  output logic                  ready,
  input  logic                  clear,
  input  logic                  update_valid,
  input  logic                  update_is_branch,
  input  logic [31:0]           update_pc,
  input  logic [31:0]           update_target,
  input  logic                  update_taken,
  input  logic [INDEX_BITS-1:0] update_bhr
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_init_cnt;
  logic [INDEX_BITS-1:0] r_bhr;

  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [31:0]           r_target [ENTRIES];
  logic [1:0]            r_bht    [ENTRIES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [INDEX_BITS-1:0] w_bht_idx;
  logic                  w_hit;
  logic                  w_taken;
  logic [31:0]           w_pc_plus4;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [INDEX_BITS-1:0] w_upd_bht_idx;
  logic                  w_upd_en;
  logic                  w_unused;

  function automatic logic [1:0] f_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign w_idx      = current_pc[INDEX_BITS+1:2];
  assign w_bht_idx  = w_idx ^ r_bhr;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == current_pc[31:INDEX_BITS+2]);
  assign w_taken    = (r_state == RUN) && w_hit && r_bht[w_bht_idx][1];
  assign w_pc_plus4 = current_pc + 32'd4;

  assign pc_predict    = w_taken ? r_target[w_idx] : w_pc_plus4;
  assign predict_taken = w_taken;
  assign lookup_bhr    = r_bhr;
  assign ready         = (r_state == RUN);

  // clear outranks a same-cycle update
  assign w_upd_en      = (r_state == RUN) && update_valid && !clear;
  assign w_upd_idx     = update_pc[INDEX_BITS+1:2];
  assign w_upd_bht_idx = w_upd_idx ^ update_bhr;

  assign w_unused = ^{current_pc[1:0], update_pc[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_bhr      <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (clear) begin
            r_init_cnt <= '0;
          end else if (&r_init_cnt) begin
            r_state    <= RUN;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + INDEX_BITS'(1);
          end
        end
        RUN: begin
          if (clear) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_bhr      <= '0;
          end else if (update_valid && update_is_branch) begin
            r_bhr <= {r_bhr[INDEX_BITS-2:0], update_taken};
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // Table contents are not reset; the INIT sweep establishes them.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_valid[r_init_cnt] <= 1'b0;
      r_bht[r_init_cnt]   <= 2'b01;
    end else if (w_upd_en) begin
      if (update_is_branch) begin
        r_bht[w_upd_bht_idx] <= f_step(r_bht[w_upd_bht_idx], update_taken);
      end else begin
        r_bht[w_upd_bht_idx] <= 2'b11;
      end
      if (!update_is_branch || update_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= update_pc[31:INDEX_BITS+2];
        r_target[w_upd_idx] <= update_target;
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb_controller.sv
// Directed bench for gshare_btb_controller: init timing, training, jumps, clear and reset.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
module tb_gshare_btb_controller;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] pc_predict;
  logic        predict_taken;
  logic [4:0]  lookup_bhr;
  logic        ready;
  logic        clear;
  logic        update_valid;
  logic        update_is_branch;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic [4:0]  update_bhr;

  int checks = 0;
  int errors = 0;

  gshare_btb_controller #(.INDEX_BITS(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_pc       (current_pc),
    .pc_predict       (pc_predict),
    .predict_taken    (predict_taken),
    .lookup_bhr       (lookup_bhr),
    .ready            (ready),
    .clear            (clear),
    .update_valid     (update_valid),
    .update_is_branch (update_is_branch),
    .update_pc        (update_pc),
    .update_target    (update_target),
    .update_taken     (update_taken),
    .update_bhr       (update_bhr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc,
                        input logic exp_taken);
    current_pc = pc;
    #1;
    chk({tag, "_pc"}, pc_predict, exp_pc);
    chk({tag, "_tk"}, {31'd0, predict_taken}, {31'd0, exp_taken});
  endtask

  task automatic do_upd(input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic [4:0] bhr);
    update_valid     = 1'b1;
    update_is_branch = br;
    update_pc        = pc;
    update_target    = tgt;
    update_taken     = tk;
    update_bhr       = bhr;
    tick();
    update_valid     = 1'b0;
  endtask

  // Counts edges from now until ready rises; expected to be exactly 32.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n, 32);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; current_pc = 32'h0;
    update_valid = 1'b0; update_is_branch = 1'b0; update_pc = 32'h0;
    update_target = 32'h0; update_taken = 1'b0; update_bhr = 5'd0;
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_bhr", {27'd0, lookup_bhr}, 32'd0);

    // INIT: pc+4 prediction, and a held jump update that must be ignored
    reset = 1'b1;
    update_valid = 1'b1; update_is_branch = 1'b0;
    update_pc = 32'h100; update_target = 32'h500; update_bhr = 5'd0;
    lookup("init", 32'h100, 32'h104, 1'b0);
    wait_ready("init_len");
    update_valid = 1'b0;
    lookup("init_upd_ignored", 32'h100, 32'h104, 1'b0);

    // Branch training at 0x40 (idx 16)
    do_upd(1'b1, 32'h40, 32'h80, 1'b1, 5'd0);
    chk("bhr_after_1", {27'd0, lookup_bhr}, 32'd1);
    lookup("br_bht_miss", 32'h40, 32'h44, 1'b0);
    do_upd(1'b1, 32'h40, 32'h80, 1'b1, 5'd15);
    do_upd(1'b1, 32'h40, 32'h80, 1'b1, 5'd15);
    do_upd(1'b1, 32'h40, 32'h80, 1'b1, 5'd15);
    chk("bhr_after_4", {27'd0, lookup_bhr}, 32'd15);
    lookup("br_sat_hit", 32'h40, 32'h80, 1'b1);

    // Jump at 0x200 (idx 0), pre-update value visible in the update cycle
    current_pc       = 32'h200;
    update_valid     = 1'b1; update_is_branch = 1'b0;
    update_pc        = 32'h200; update_target = 32'h1000; update_bhr = 5'd15;
    #1;
    chk("jmp_same_cycle", pc_predict, 32'h204);
    @(posedge clk); #1;
    update_valid = 1'b0;
    lookup("jmp_hit", 32'h200, 32'h1000, 1'b1);
    chk("jmp_bhr_same", {27'd0, lookup_bhr}, 32'd15);
    lookup("alias", 32'h280, 32'h284, 1'b0);

    // Direct-mapped overwrite by the alias
    do_upd(1'b0, 32'h280, 32'h2000, 1'b0, 5'd15);
    lookup("ovw_new", 32'h280, 32'h2000, 1'b1);
    lookup("ovw_old", 32'h200, 32'h204, 1'b0);

    // Clear with a simultaneous update: update dropped, tables re-initialised
    clear = 1'b1;
    do_upd(1'b0, 32'h300, 32'h3000, 1'b0, 5'd15);
    clear = 1'b0;
    chk("clr_ready", {31'd0, ready}, 32'd0);
    chk("clr_bhr", {27'd0, lookup_bhr}, 32'd0);
    wait_ready("clr_len");
    lookup("clr_40", 32'h40, 32'h44, 1'b0);
    lookup("clr_280", 32'h280, 32'h284, 1'b0);
    lookup("clr_300", 32'h300, 32'h304, 1'b0);

    // Asynchronous reset in RUN, then a reset pulse mid-INIT
    do_upd(1'b1, 32'h40, 32'h80, 1'b1, 5'd0);
    chk("pre_rst_bhr", {27'd0, lookup_bhr}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_bhr", {27'd0, lookup_bhr}, 32'd0);
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("mid_init_ready", {31'd0, ready}, 32'd0);
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_ready("rst_mid_len");
    lookup("wrap", 32'hFFFFFFFC, 32'h00000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/gshare_btb_controller.md
GSHARE_BTB_CONTROLLER -- requirements
Module: gshare_btb_controller

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 5, giving the table index width (2^INDEX_BITS entries; 32 by default).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port current_pc, input, 32, the fetch PC to predict.
REQ-005 The block SHALL have port pc_predict, output, 32, the predicted next fetch PC.
REQ-006 The block SHALL have port predict_taken, output, 1, the prediction direction, carried down the pipe by the core.
REQ-007 The block SHALL have port lookup_bhr, output, INDEX_BITS, the current global history, carried down the pipe with the instruction.
REQ-008 The block SHALL have port ready, output, 1, high when tables are initialised and predicting.
REQ-009 The block SHALL have port clear, input, 1, a synchronous request to re-initialise all tables.
REQ-010 The block SHALL have port update_valid, input, 1, resolution of one control-flow instruction this cycle.
REQ-011 The block SHALL have port update_is_branch, input, 1: 1 = conditional branch, 0 = unconditional jump.
REQ-012 The block SHALL have ports update_pc, input, 32, and update_target, input, 32: the resolved instruction PC and its target.
REQ-013 The block SHALL have port update_taken, input, 1, the resolved direction.
REQ-014 The block SHALL have port update_bhr, input, INDEX_BITS, the lookup_bhr snapshot taken at prediction time.

Function
REQ-015 Storage SHALL be:
- BTB: per entry, valid, tag = pc[31:INDEX_BITS+2] and a 32-bit target; indexed by pc[INDEX_BITS+1:2].
- BHT: 2-bit saturating counters indexed by pc[INDEX_BITS+1:2] XOR history.
- BHR: INDEX_BITS-bit global history register.
REQ-016 The FSM SHALL have two states, INIT and RUN; ready = (state == RUN).
REQ-017 In INIT, per cycle, the block SHALL clear valid[init_cnt] and set BHT[init_cnt] = 2'b01 (weakly not-taken), then increment init_cnt.
REQ-018 INIT SHALL move to RUN on the edge where init_cnt = 2^INDEX_BITS-1, so INIT lasts exactly 2^INDEX_BITS cycles.
REQ-019 In INIT, outputs SHALL be predict_taken = 0 and pc_predict = current_pc + 4, and update_valid SHALL be ignored.
REQ-020 In RUN, lookup SHALL be combinational: hit = valid && tag match at the BTB index; predict_taken = hit && BHT[idx XOR BHR][1]; pc_predict = predict_taken ? target : current_pc + 4.
REQ-021 A clear in RUN SHALL set state = INIT, init_cnt = 0 and BHR = 0 at the next edge. A clear in INIT SHALL restart init_cnt at 0.
REQ-022 A conditional-branch update (RUN, update_valid, update_is_branch) SHALL:
- move BHT[update_pc idx XOR update_bhr] one step toward update_taken, saturating at 2'b00 and 2'b11;
- shift BHR left, inserting update_taken at the LSB;
- if update_taken, write the BTB entry (valid = 1, tag, update_target).
REQ-023 A jump update (RUN, update_valid, !update_is_branch) SHALL write the BTB entry, set BHT[update_pc idx XOR update_bhr] = 2'b11 and leave BHR unchanged.
REQ-024 When clear and update_valid occur in the same cycle, clear SHALL win and the update SHALL be dropped.
REQ-025 When an update and a lookup address the same entry in the same cycle, the lookup SHALL see the pre-update contents; the new value SHALL be visible from the next cycle.
REQ-026 pc + 4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000). A BTB write to an occupied index SHALL overwrite it (direct-mapped).

Reset
REQ-027 When reset is low, the block SHALL immediately force state = INIT, init_cnt = 0, BHR = 0 and ready = 0, including mid-INIT and mid-update. Table contents need no reset; INIT overwrites them.
REQ-028 After reset is released, ready SHALL rise after exactly 2^INDEX_BITS clk edges.

Verification
REQ-029 Reset release -> ready = 0 for 32 cycles, then 1. During INIT, current_pc = 32'h100 gives pc_predict = 32'h104 and predict_taken = 0. An update_valid during INIT has no effect.
REQ-030 Train branch pc = 32'h40, target = 32'h80, taken, bhr = 0 -> next lookup of 32'h40 with BHR = 5'b00001 misses the BHT (index differs). Repeating the update with the snapshot bhr reaches counter 2'b11, saturates, and subsequent matching lookups give pc_predict = 32'h80.
REQ-031 Jump update pc = 32'h200, target = 32'h1000 -> next cycle a lookup of 32'h200 with matching history predicts 32'h1000 and BHR is unchanged. Tag alias 32'h280 (same index, different tag) predicts 32'h284.
REQ-032 Issue clear and update_valid in the same cycle -> update dropped, ready low for 32 cycles, all prior BTB hits gone afterwards.
REQ-033 Pulse reset low mid-INIT (init_cnt = 10) -> init_cnt restarts at 0 and ready rises 32 cycles after release. current_pc = 32'hFFFFFFFC on a miss gives pc_predict = 32'h00000000.
